ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of single_port_ram (registered
//  read address + registered output, separate rd/wr address, one write port). After
//  reset it clears every RAM word, then shares the RAM one access per cycle between
//  requesters 0 and 1 and routes read data back with its own valid strobe.
// PARAMETERS
//  DATA_WIDTH  16  RAM word width
//  ADDR_WIDTH  5   RAM address width; depth = 2**ADDR_WIDTH
//  INIT_VALUE  0   word written to every location during the INIT sweep
// PORTS
//  clk          in   1   clock, all logic on posedge
//  reset        in   1   asynchronous, active-high reset
//  req0/req1    in   1   requester N wants an access this cycle
//  we0/we1      in   1   1 = write, 0 = read (sampled with reqN)
//  addr0/addr1  in   AW  access address
//  wdata0/1     in   DW  write data
//  gnt0/gnt1    out  1   combinational grant; access accepted when reqN && gntN
//  rvalid0/1    out  1   read data valid for requester N
//  rdata0/1     out  DW  read data (= ram_q, qualified by rvalidN)
//  init_done    out  1   high once INIT sweep finished
//  ram_data     out  DW  to RAM data
//  ram_rdaddr   out  AW  to RAM rdaddr
//  ram_wraddr   out  AW  to RAM wraddr
//  ram_we       out  1   to RAM we
//  ram_q        in   DW  from RAM q
// BEHAVIOUR
//  Reset (async): state=INIT, init_cnt=0, rr_last=1, rd pipe valids=0, init_done=0,
//   gnt*=0, rvalid*=0. Reset mid-INIT restarts sweep at 0; mid-read discards pending reads.
//  FSM INIT: each cycle ram_we=1, ram_wraddr=init_cnt, ram_data=INIT_VALUE; init_cnt++.
//   After writing address 2**AW-1 -> RUN. init_done=1 from first RUN cycle (32 cycles
//   of INIT at defaults). gnt*=0 throughout INIT; requests ignored, not queued.
//  FSM RUN (never leaves except via reset):
//   - only req0 -> gnt0; only req1 -> gnt1; both -> grant the one != rr_last; none -> none.
//   - rr_last <= granted index on every accepted access; unchanged on idle cycles.
//   - exactly one gnt high at most per cycle; gnt depends on req0/req1 only (not we/addr).
//   - granted write: ram_we=1, ram_wraddr=addr, ram_data=wdata, same cycle.
//   - granted read: ram_rdaddr=addr, ram_we=0. Idle/write cycles: ram_rdaddr holds last
//     read address (no spurious toggling); ram_we=0 when idle.
//  Read latency: read accepted in cycle t -> rvalidN high for exactly cycle t+2 with
//   rdataN=ram_q. Tracked by 2-stage {valid,id} shift pipe; back-to-back reads
//   (either requester, every cycle) fully pipelined, returned in acceptance order.
//  Ordering: a read accepted in cycle t returns data including all writes accepted in
//   cycles < t; a write accepted in t+1 does NOT affect it (RAM samples before write).
//  rvalid of non-owner stays 0; rdata1/rdata0 may both mirror ram_q.
//  Widths: init_cnt is AW+1 bits so terminal count detect has no wrap ambiguity.
// TESTING
//  1 Reset, hold req0=1 -> gnt0=0 for 32 cycles, ram_we=1 addr 0..31 data 0, init_done
//    rises next cycle; then read addr 7 -> rvalid0 2 cycles later, rdata0=0.
//  2 req0 write addr3=0xBEEF, next cycle req0 read addr3 -> rdata0=0xBEEF at t+2.
//  3 req0 and req1 both held 6 cycles (reads) -> grants 0,1,0,1,0,1; rvalid0/rvalid1
//    alternate, each 2 cycles after its grant.
//  4 req1 read addr5 in t, req0 write addr5=0x1234 in t+1 -> rdata1=old value;
//    subsequent read -> 0x1234.
//  5 Reads accepted t and t+1, reset asserted at t+1 -> no rvalid ever appears;
//    INIT sweep restarts at address 0.
//  6 Only req1 for 4 cycles, then both -> req0 wins first contended cycle (rr_last=1).

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin sequencer in front of a single-port RAM with a
// registered read address and a registered output. After reset it clears every
// RAM word, then shares the RAM one access per cycle between requesters 0 and
// 1. Read data comes back two cycles after acceptance with a per-requester valid.
module ram_port_arbiter #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  init_done,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  output logic [ADDR_WIDTH-1:0] ram_wraddr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // The sweep counter is one bit wider than the address so the terminal
  // compare can never alias with a wrapped value.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH:0]     init_cnt;
  logic                    rr_last;

  // Accepted access in the current cycle (stage 0, combinational)
  logic                    acc_vld;
  logic                    acc_id;
  logic                    acc_we;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;

  // Read-return tracking pipe: p0 = RAM has latched the address,
  // p1 = RAM output register holds the data.
  logic                    vld_p0;
  logic                    vld_p1;
  logic                    id_p0;
  logic                    id_p1;

  // Last read address, replayed on idle/write cycles so the RAM read port
  // does not toggle needlessly.
  logic [ADDR_WIDTH-1:0]   rd_addr_hold;

  // State register, sweep counter, round-robin pointer and read-pipe valids
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rr_last  <= 1'b1;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
      end
      if (acc_vld) begin
        rr_last <= acc_id;
      end
      // stage 0 -> stage 1: read accepted, RAM latches its address
      vld_p0 <= acc_vld && !acc_we;
      // stage 1 -> stage 2: RAM output register loads the word
      vld_p1 <= vld_p0;
    end
  end

  // Requester id travels with the valid; the read-address hold follows reads
  always_ff @(posedge clk) begin
    id_p0 <= acc_id;
    id_p1 <= id_p0;
    if (acc_vld && !acc_we) begin
      rd_addr_hold <= acc_addr;
    end
  end

  // Next state, arbitration and RAM port steering
  always_comb begin
    state_nxt  = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    acc_vld    = 1'b0;
    acc_id     = 1'b0;
    acc_we     = 1'b0;
    acc_addr   = addr0;
    acc_wdata  = wdata0;
    ram_we     = 1'b0;
    ram_wraddr = init_cnt[ADDR_WIDTH-1:0];
    ram_data   = INIT_VALUE;
    ram_rdaddr = rd_addr_hold;

    case (state)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_wraddr = init_cnt[ADDR_WIDTH-1:0];
        ram_data   = INIT_VALUE;
        if (init_cnt == LAST_ADDR) begin
          state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        // Requester 0 wins when alone, or when contended and 1 was served last.
        if (req0 && (!req1 || rr_last)) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end

        if (gnt0) begin
          acc_vld   = 1'b1;
          acc_id    = 1'b0;
          acc_we    = we0;
          acc_addr  = addr0;
          acc_wdata = wdata0;
        end else if (gnt1) begin
          acc_vld   = 1'b1;
          acc_id    = 1'b1;
          acc_we    = we1;
          acc_addr  = addr1;
          acc_wdata = wdata1;
        end

        ram_wraddr = acc_addr;
        ram_data   = acc_wdata;
        if (acc_vld && acc_we) begin
          ram_we = 1'b1;
        end
        if (acc_vld && !acc_we) begin
          ram_rdaddr = acc_addr;
        end
      end

      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign init_done = (state == ST_RUN);

  // stage 2: RAM output is live, steer the strobe to the owner
  assign rvalid0 = vld_p1 && !id_p1;
  assign rvalid1 = vld_p1 && id_p1;
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule
